// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants and helpers for the buffered UART transmitter
// Purpose: state encoding, data width and baud divider helper used by
//          uart_tx_buf and uart_byte_fifo.
// Ports:   none (package).
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  // Clocks per bit; integer division, so the line rate rounds toward faster.
  function automatic int calc_bit_cnt(input int clk_freq, input int uart_bps);
    return clk_freq / uart_bps;
  endfunction

endpackage

// File: rtl/uart_byte_fifo.sv
// rtl/uart_byte_fifo.sv - single-clock synchronous byte FIFO with registered read
// Purpose: queues bytes between the write strobe and the serialiser.
// Ports:   clk, rst (async, active-high)
//          wr_en/wr_data  - push when not full
//          rd_en/rd_data  - pop when not empty; rd_data valid the cycle after rd_en
//          full/empty     - derived from level
//          level          - occupancy, 0..DEPTH
module uart_byte_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_LVL = DEPTH[PW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign full  = (level == FULL_LVL);
  assign empty = (level == '0);
  // A write to a full FIFO is refused even if a pop frees a slot this cycle.
  assign do_wr = wr_en & ~full;
  assign do_rd = rd_en & ~empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      rd_data <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) begin
        rd_ptr  <= rd_ptr + 1'b1;
        rd_data <= mem[rd_ptr];
      end
      case ({do_wr, do_rd})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Storage needs no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_buf.sv
// rtl/uart_tx_buf.sv - buffered 8N1/8E1/8O1 UART transmitter
// Purpose: absorbs single-cycle byte strobes into a FIFO and serialises them
//          back-to-back on a registered serial line.
// Ports:   clk, rst (async, active-high)
//          tx_wr_en/tx_wr_data - byte strobe in
//          tx_full/tx_empty/tx_level - FIFO status
//          tx_overflow - one-cycle pulse when a write is dropped
//          tx_busy     - frame on the line
//          uart_tx_data - serial out, idle high
module uart_tx_buf import uart_pkg::*; #(
  parameter int CLK_FREQ   = 50000000,
  parameter int UART_BPS   = 115200,
  parameter int FIFO_DEPTH = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          tx_wr_en,
  input  logic [UART_DATA_W-1:0]        tx_wr_data,
  output logic                          tx_full,
  output logic                          tx_empty,
  output logic [$clog2(FIFO_DEPTH):0]   tx_level,
  output logic                          tx_overflow,
  output logic                          tx_busy,
  output logic                          uart_tx_data
);

  localparam int BIT_CNT = calc_bit_cnt(CLK_FREQ, UART_BPS);
  localparam int BW      = (BIT_CNT > 1) ? $clog2(BIT_CNT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(BIT_CNT - 1);

  tx_state_t              state;
  tx_state_t              state_next;
  logic [BW-1:0]          baud_cnt;
  logic [2:0]             bit_idx;
  logic [UART_DATA_W-1:0] shreg;
  logic                   par_bit;
  logic                   tx_reg;
  logic                   tx_next;
  logic                   rd_en;
  logic                   bit_end;
  logic [UART_DATA_W-1:0] fifo_rd_data;

  uart_byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (UART_DATA_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (tx_wr_en),
    .wr_data (tx_wr_data),
    .rd_en   (rd_en),
    .rd_data (fifo_rd_data),
    .full    (tx_full),
    .empty   (tx_empty),
    .level   (tx_level)
  );

  assign bit_end      = (state != IDLE) && (baud_cnt == BAUD_LAST);
  assign tx_busy      = (state != IDLE);
  assign uart_tx_data = tx_reg;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (!tx_empty) state_next = START;
      START:   if (bit_end) state_next = DATA;
      DATA:    if (bit_end && bit_idx == 3'd7)
                 state_next = (PARITY_EN != 0) ? PARITY : STOP;
      PARITY:  if (bit_end) state_next = STOP;
      STOP:    if (bit_end) state_next = tx_empty ? IDLE : START;
      default: state_next = IDLE;
    endcase
  end

  // Output logic: pop request and the next line level. The line is registered,
  // so it trails the state by one clock; this is the extra cycle between pop
  // and start bit, and it keeps the line aligned with the FIFO's read latency.
  always_comb begin
    rd_en   = 1'b0;
    tx_next = 1'b1;
    case (state)
      IDLE:    rd_en   = !tx_empty;
      START:   tx_next = 1'b0;
      DATA:    tx_next = shreg[0];
      PARITY:  tx_next = par_bit;
      STOP:    rd_en   = bit_end && !tx_empty;
      default: tx_next = 1'b1;
    endcase
  end

  // Baud counter, bit index, shifter and registered line
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      baud_cnt    <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      par_bit     <= 1'b0;
      tx_reg      <= 1'b1;
      tx_overflow <= 1'b0;
    end else begin
      tx_reg      <= tx_next;
      tx_overflow <= tx_wr_en & tx_full;

      if (state == IDLE || bit_end) baud_cnt <= '0;
      else                          baud_cnt <= baud_cnt + 1'b1;

      // The popped byte sits in the FIFO read register for the whole frame;
      // it is captured into the shifter while the start bit is still going out.
      if (state == START && bit_end) begin
        shreg   <= fifo_rd_data;
        par_bit <= (^fifo_rd_data) ^ PARITY_ODD[0];
      end else if (state == DATA && bit_end) begin
        shreg <= shreg >> 1;
      end

      if (state == DATA && bit_end) bit_idx <= bit_idx + 3'd1;
      else if (state != DATA)       bit_idx <= '0;
    end
  end

endmodule

// File: doc/uart_tx_buf.md
Name: uart_tx_buf

Overview:
- Buffered UART transmitter. It accepts bytes from a single-cycle strobe interface, the same done/data style the UART receiver produces.
- Bytes are queued in an internal FIFO and serialised as 8N1 frames, or 8E1/8O1 frames when parity is enabled.
- Sits between the receiver output (or any byte producer) and the uart_tx pin. Bursts arriving faster than line rate are absorbed rather than lost.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- UART_BPS, 115200, line baud rate; BIT_CNT = CLK_FREQ/UART_BPS clocks per bit (integer division).
- FIFO_DEPTH, 16, byte entries; must be a power of 2, at least 2.
- PARITY_EN, 0, 1 inserts a parity bit between data and stop.
- PARITY_ODD, 0, 0 gives even parity, 1 gives odd parity; ignored when PARITY_EN=0.

Ports:
- clk  input  1  system clock, all logic rising-edge.
- rst  input  1  asynchronous, active-high reset.
- tx_wr_en  input  1  write strobe, one byte per asserted cycle.
- tx_wr_data  input  8  byte to queue.
- tx_full  output  1  FIFO holds FIFO_DEPTH entries.
- tx_empty  output  1  FIFO holds 0 entries.
- tx_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- tx_overflow  output  1  one-cycle pulse when a write is dropped.
- tx_busy  output  1  a frame is on the line (state != IDLE).
- uart_tx_data  output  1  serial line, idle high.

Behaviour:
- Reset (asynchronous): uart_tx_data=1, tx_busy=0, tx_empty=1, tx_full=0, tx_level=0, tx_overflow=0.
  - FIFO pointers are cleared; FIFO contents do not matter.
  - The FSM goes to IDLE and the bit and baud counters go to 0.
  - A frame in progress is abandoned; the line returns high immediately.
- FIFO write: accepted when tx_wr_en=1 and tx_full=0, where tx_full is the registered value.
  - Writing while full drops the byte and pulses tx_overflow for 1 cycle. Contents are unchanged.
  - A write and a pop in the same cycle are both accepted when not full; tx_level is unchanged.
  - A write to a full FIFO is rejected even if a pop occurs that cycle.
- Pointers are $clog2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. tx_level is tracked as a separate counter, and full/empty are derived from tx_level.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - When tx_empty=0: pop the head byte into a shift register and compute parity.
  - Go to START on the next edge; the start bit appears on uart_tx_data 1 cycle after the pop cycle.
  - From a write into an empty idle FIFO to the start-bit edge is 2 cycles.
- START: drive 0 for BIT_CNT clocks, then go to DATA.
- DATA: drive data bits LSB first, BIT_CNT clocks each; a 3-bit index runs 0..7. After bit 7, go to PARITY if PARITY_EN=1, otherwise go to STOP.
- PARITY: drive (^byte) XOR PARITY_ODD for BIT_CNT clocks, then go to STOP.
- STOP: drive 1 for BIT_CNT clocks.
  - In the last clock of STOP, if tx_empty=0, pop the next byte and go directly to START. This gives back-to-back frames with no idle gap.
  - Otherwise go to IDLE.
- Baud counter runs 0..BIT_CNT-1; reaching BIT_CNT-1 ends the bit and reloads 0. The counter is held at 0 in IDLE.
- Frame length is (10 + PARITY_EN) × BIT_CNT clocks exactly.
- uart_tx_data is driven from a register (no combinational output path). Its value is 1 in IDLE.
- tx_busy is 1 from the START entry edge through the last STOP clock. It stays 1 continuously across back-to-back frames.
- Writes never affect the frame in flight; the shift register is loaded only at pop.

Decomposition:
- Shared package uart_pkg holds:
  - state encoding constants (IDLE/START/DATA/PARITY/STOP);
  - UART_DATA_W=8;
  - a function computing BIT_CNT from CLK_FREQ/UART_BPS.
- One sub-module: uart_byte_fifo, a synchronous single-clock FIFO.
  - Parameters DEPTH and WIDTH.
  - Ports wr_en/wr_data/rd_en/rd_data/full/empty/level.
  - Registered read data is available 1 cycle after rd_en; the FSM accounts for this in the pop-to-START timing.
- The FSM, baud counter and shifter live in uart_tx_buf.

Test Plan:
All scenarios use CLK_FREQ=1000000 and UART_BPS=100000, so BIT_CNT=10.
- Single byte 0xA5 written while idle, PARITY_EN=0 -> start bit begins 2 cycles after the write. Line shows 0,1,0,1,0,0,1,0,1,1 (start bit, then data LSB first, then stop), each bit held 10 clocks. tx_busy is high for exactly 100 clocks, after which tx_empty=1.
- Burst of 16 writes 0x00..0x0F on consecutive cycles -> tx_level peaks at 15 (the first byte is popped immediately). 16 frames are sent back-to-back with no idle cycle between stop and start, totalling 1600 clocks, and tx_overflow never pulses.
- With the FIFO full and a frame in flight, write 0x77 -> tx_overflow pulses for 1 cycle, tx_level stays 16, and 0x77 never appears on the line.
- PARITY_EN=1, PARITY_ODD=0, byte 0x07 -> parity bit is 1 and the frame is 110 clocks. With PARITY_ODD=1 the parity bit is 0.
- Simultaneous write and pop at the last STOP clock with tx_level=3 -> tx_level stays 3 and byte ordering is preserved.
- Assert rst mid-DATA (bit 4 of 0x3C) with 5 bytes queued -> uart_tx_data=1 asynchronously, tx_level=0, tx_busy=0. After release the line stays idle until a new write, and the next frame carries only the new byte.
